ternary_word_deser: RTL and testbench

- Receives a digit-serial stream of trits in the team's two-wire ternary encoding and reassembles each group of NTRITS trits into one unsigned binary word.
- Receive end of the ternary datapath: trits produced by the ternary logic gates (max/consensus network outputs) are serialised upstream, and this block converts them back to binary for the rest of the system.
- Valid/ready handshake on both sides. Invalid trit codes are flagged per word.

---
 rtl/ternary_pkg.sv | 15 +
 rtl/trit_decode.sv | 24 ++
 rtl/ternary_word_deser.sv | 109 ++++++++++
 tb/tb_ternary_word_deser.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ternary_pkg.sv
// Shared ternary datapath definitions: two-wire trit codes ({t0,t1}) and
// the receive-side deserializer state encoding.
package ternary_pkg;

  localparam logic [1:0] TRIT_ZERO = 2'b00;
  localparam logic [1:0] TRIT_ONE  = 2'b01;
  localparam logic [1:0] TRIT_TWO  = 2'b10;
  localparam logic [1:0] TRIT_BAD  = 2'b11;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } deser_state_t;

endpackage

// File: rtl/trit_decode.sv
// Combinational two-wire trit decoder: {t0,t1} -> binary digit 0..2.
// The illegal code 11 decodes as digit 0 and raises o_invalid.
module trit_decode
  import ternary_pkg::*;
(
  input  logic       i_t0,
  input  logic       i_t1,
  output logic [1:0] o_digit,
  output logic       o_invalid
);

  always_comb begin
    o_digit   = 2'd0;
    o_invalid = 1'b0;
    case ({i_t0, i_t1})
      TRIT_ZERO: o_digit   = 2'd0;
      TRIT_ONE:  o_digit   = 2'd1;
      TRIT_TWO:  o_digit   = 2'd2;
      TRIT_BAD:  o_invalid = 1'b1;
      default:   o_digit   = 2'd0;
    endcase
  end

endmodule

// File: rtl/ternary_word_deser.sv
// Reassembles NTRITS serial trits (MS trit first) into one unsigned binary
// word, with valid/ready on both sides and a sticky per-word error flag.
module ternary_word_deser
  import ternary_pkg::*;
#(
  parameter int NTRITS = 5,
  parameter int WIDTH  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync_clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             t0,
  input  logic             t1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);

  localparam int            CW   = $clog2(NTRITS + 1);
  localparam logic [CW-1:0] LAST = CW'(NTRITS - 1);

  // The largest word (3^NTRITS - 1) must fit in WIDTH bits.
  generate
    if (NTRITS < 1) begin : g_bad_ntrits
      $fatal(1, "ternary_word_deser: NTRITS must be >= 1");
    end
    if ((64'd3 ** NTRITS) > (64'd1 << WIDTH)) begin : g_bad_width
      $fatal(1, "ternary_word_deser: WIDTH too small for 3^NTRITS - 1");
    end
  endgenerate

  deser_state_t     r_state;
  deser_state_t     w_next_state;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_next;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_next;
  logic             r_err;
  logic             w_err_next;
  logic [1:0]       w_digit;
  logic             w_invalid;

  trit_decode u_trit_decode (
    .i_t0      (t0),
    .i_t1      (t1),
    .o_digit   (w_digit),
    .o_invalid (w_invalid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= COLLECT;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_acc   <= w_acc_next;
      r_cnt   <= w_cnt_next;
      r_err   <= w_err_next;
    end
  end

  // sync_clr outranks every handshake, so a held word vanishes silently.
  always_comb begin
    w_next_state = r_state;
    w_acc_next   = r_acc;
    w_cnt_next   = r_cnt;
    w_err_next   = r_err;
    if (sync_clr) begin
      w_next_state = COLLECT;
      w_acc_next   = '0;
      w_cnt_next   = '0;
      w_err_next   = 1'b0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (in_valid) begin
            w_acc_next = (r_acc << 1) + r_acc + WIDTH'(w_digit);
            w_err_next = r_err | w_invalid;
            if (r_cnt == LAST) begin
              w_next_state = HOLD;
              w_cnt_next   = '0;
            end else begin
              w_cnt_next = r_cnt + CW'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            w_next_state = COLLECT;
            w_acc_next   = '0;
            w_err_next   = 1'b0;
          end
        end
        default: w_next_state = COLLECT;
      endcase
    end
  end

  assign in_ready  = (r_state == COLLECT);
  assign out_valid = (r_state == HOLD);
  assign out_data  = r_acc;
  assign out_err   = r_err;

endmodule

// File: tb/tb_ternary_word_deser.sv
// Self-checking bench for ternary_word_deser (NTRITS=5, WIDTH=8): directed
// steps plus random words checked against a base-3 arithmetic model.
module tb_ternary_word_deser;

  localparam int NT = 5;
  localparam int W  = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sync_clr = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         t0 = 1'b0;
  logic         t1 = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  ternary_word_deser #(.NTRITS(NT), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sync_clr  (sync_clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .t0        (t0),
    .t1        (t1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: a word is the base-3 number spelled by its trits, code 11 counting as 0.
  function automatic int refValue(input logic [2*NT-1:0] codes);
    int val = 0;
    for (int i = NT - 1; i >= 0; i--) begin
      int code = int'(codes[2*i +: 2]);
      val = val * 3 + ((code == 3) ? 0 : code);
    end
    return val;
  endfunction

  function automatic int refErr(input logic [2*NT-1:0] codes);
    int bad = 0;
    for (int i = 0; i < NT; i++) if (codes[2*i +: 2] == 2'b11) bad = 1;
    return bad;
  endfunction

  function automatic logic [2*NT-1:0] randCodes(input bit allowBad);
    logic [2*NT-1:0] c;
    for (int i = 0; i < NT; i++) c[2*i +: 2] = 2'($urandom_range(0, allowBad ? 3 : 2));
    return c;
  endfunction

  task automatic applyStimulus(input logic [1:0] code);
    bit done = 0;
    {t0, t1} = code;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (in_ready === 1'b1) done = 1;
      @(posedge clk);
      @(negedge clk);
    end
    if (!done) checkOutput("accept_timeout", {31'd0, in_ready}, 1);
  endtask

  task automatic sendWord(input logic [2*NT-1:0] codes, input bit keepValid);
    for (int i = NT - 1; i >= 0; i--) applyStimulus(codes[2*i +: 2]);
    if (!keepValid) in_valid = 1'b0;
  endtask

  task automatic expectHeld(input string tag, input logic [2*NT-1:0] codes);
    checkOutput({tag, "_valid"}, {31'd0, out_valid}, 1);
    checkOutput({tag, "_data"}, {24'd0, out_data}, refValue(codes));
    checkOutput({tag, "_err"}, {31'd0, out_err}, refErr(codes));
    checkOutput({tag, "_inready"}, {31'd0, in_ready}, 0);
  endtask

  task automatic popWord(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_popvalid"}, {31'd0, out_valid}, 0);
    checkOutput({tag, "_popready"}, {31'd0, in_ready}, 1);
  endtask

  initial begin
    logic [2*NT-1:0] w;
    logic [2*NT-1:0] w2;
    logic [1:0]      h;
    int              startCyc;

    // Reset, then an asynchronous reset in the middle of a word.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_inready", {31'd0, in_ready}, 1);
    checkOutput("rst_outvalid", {31'd0, out_valid}, 0);
    applyStimulus(2'b10);
    applyStimulus(2'b10);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_inready", {31'd0, in_ready}, 1);
    checkOutput("midrst_outvalid", {31'd0, out_valid}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    w = 10'b01_01_01_01_01;
    sendWord(w, 0);
    expectHeld("ones", w);
    checkOutput("ones_value", {24'd0, out_data}, 121);
    popWord("ones");

    // 2,1,0,2,1 streamed with out_ready high: valid for exactly one cycle.
    out_ready = 1'b1;
    w = 10'b10_01_00_10_01;
    sendWord(w, 0);
    expectHeld("c4", w);
    checkOutput("c4_value", {24'd0, out_data}, 196);
    @(negedge clk);
    checkOutput("c4_onecycle", {31'd0, out_valid}, 0);

    // Max word then zeros back to back; second word costs NT+1 cycles.
    w = 10'b10_10_10_10_10;
    sendWord(w, 1);
    expectHeld("max", w);
    checkOutput("max_value", {24'd0, out_data}, 242);
    startCyc = cyc;
    w = '0;
    sendWord(w, 0);
    checkOutput("bubble_period", startCyc + NT + 1, cyc);
    expectHeld("zero", w);
    @(negedge clk);
    checkOutput("zero_gone", {31'd0, out_valid}, 0);
    out_ready = 1'b0;

    // Invalid trit flags only its own word.
    w = 10'b01_01_11_00_00;
    sendWord(w, 0);
    expectHeld("bad", w);
    checkOutput("bad_value", {24'd0, out_data}, 108);
    checkOutput("bad_flag", {31'd0, out_err}, 1);
    popWord("bad");
    w = randCodes(0);
    sendWord(w, 0);
    expectHeld("clean_after_bad", w);
    popWord("clean_after_bad");

    // Backpressure: trits offered during HOLD must not be consumed.
    w = randCodes(0);
    sendWord(w, 1);
    expectHeld("bp", w);
    h = 2'b00;
    for (int k = 0; k < 4; k++) begin
      h = 2'($urandom_range(0, 2));
      {t0, t1} = h;
      @(posedge clk);
      @(negedge clk);
      expectHeld("bp_hold", w);
    end
    popWord("bp");
    w2 = randCodes(0);
    w2[2*NT-1 -: 2] = h;
    sendWord(w2, 0);
    expectHeld("bp_next", w2);
    popWord("bp_next");

    // sync_clr on a partial word, with a trit presented the same cycle.
    w = randCodes(1);
    for (int i = NT - 1; i >= NT - 3; i--) applyStimulus(w[2*i +: 2]);
    sync_clr = 1'b1;
    {t0, t1} = 2'b10;
    @(posedge clk);
    @(negedge clk);
    sync_clr = 1'b0;
    in_valid = 1'b0;
    checkOutput("clr_part_inready", {31'd0, in_ready}, 1);
    checkOutput("clr_part_outvalid", {31'd0, out_valid}, 0);
    w = 10'b00_00_00_01_10;
    sendWord(w, 0);
    expectHeld("clr_part_next", w);
    checkOutput("clr_part_value", {24'd0, out_data}, 5);
    popWord("clr_part_next");

    // sync_clr in HOLD together with out_ready drops the held word.
    w2 = randCodes(1);
    sendWord(w2, 0);
    expectHeld("clr_hold", w2);
    sync_clr = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sync_clr = 1'b0;
    out_ready = 1'b0;
    checkOutput("clr_hold_outvalid", {31'd0, out_valid}, 0);
    checkOutput("clr_hold_inready", {31'd0, in_ready}, 1);
    sendWord(w, 0);
    expectHeld("clr_hold_next", w);
    checkOutput("clr_hold_value", {24'd0, out_data}, 5);
    popWord("clr_hold_next");

    // Random words with random downstream stalls.
    for (int n = 0; n < 15; n++) begin
      w = randCodes(1);
      sendWord(w, ($urandom_range(0, 1) == 1));
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        @(negedge clk);
      end
      expectHeld("rand", w);
      popWord("rand");
    end
    in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
